ifu: RTL and testbench
======================

IFU -- requirements
Module: ifu

Interface
REQ-001 Parameter RESET_PC, default 64'h8000_0000, SHALL be the fetch address after reset.
REQ-002 Parameter NOP_INST, default 32'h0000_0013, SHALL be the out_inst value on a fault.
REQ-003 clk  input  1  sole clock; all state SHALL update on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 redirect_valid  input  1  execute-stage redirect (jal/jalr/taken branch).
REQ-006 redirect_pc  input  64  redirect target.
REQ-007 imem_req_valid  output  1  fetch request valid.
REQ-008 imem_req_ready  input  1  memory accepts request.
REQ-009 imem_req_addr  output  64  fetch address.
REQ-010 imem_rsp_valid  input  1  response valid.
REQ-011 imem_rsp_ready  output  1  IFU accepts response.
REQ-012 imem_rsp_data  input  32  fetched instruction.
REQ-013 imem_rsp_err  input  1  access fault on response.
REQ-014 out_valid  output  1  instruction available to IF/ID register.
REQ-015 out_ready  input  1  IF/ID register accepts.
REQ-016 out_pc  output  64  pc of delivered instruction.
REQ-017 out_inst  output  32  delivered instruction.
REQ-018 out_fault  output  1  fetch fault (access error or misaligned pc).
REQ-019 fetch_count  output  64  count of delivered instructions.

Function
REQ-020 FSM states: REQ, WAIT, OUT; one memory request outstanding at most; one output buffer entry.
REQ-021 REQ: imem_req_valid = !redirect_valid; imem_req_addr = pc; handshake (valid&ready) -> WAIT, req_pc <= pc.
REQ-022 Once imem_req_valid is high without redirect, imem_req_addr SHALL stay stable until handshake.
REQ-023 WAIT: imem_rsp_ready = 1; imem_rsp_ready = 0 in all other states.
REQ-024 WAIT, rsp handshake, kill = 0, no redirect: buffer <= {req_pc, imem_rsp_data, imem_rsp_err} -> OUT.
REQ-025 Buffered fault: out_inst SHALL read NOP_INST and out_fault SHALL read 1 regardless of response data.
REQ-026 OUT: out_valid = !redirect_valid; on out_valid&out_ready: pc <= out_pc + 4 (64-bit wrap), fetch_count += 1 (wrap), -> REQ.
REQ-027 Redirect has top priority in every state: pc <= {redirect_pc[63:1], 1'b0}.
REQ-028 Redirect in REQ: no request issued that cycle; stay REQ.
REQ-029 Redirect in WAIT without same-cycle response: kill <= 1; stay WAIT.
REQ-030 Redirect in WAIT with same-cycle response: response consumed and dropped; kill <= 0; -> REQ.
REQ-031 WAIT, rsp handshake with kill = 1, no redirect: response dropped; kill <= 0; -> REQ.
REQ-032 Repeated redirects while kill = 1 SHALL only update pc; exactly one response SHALL be dropped.
REQ-033 Redirect in OUT: buffered instruction discarded (no out handshake, no count); -> REQ.
REQ-034 REQ with pc[1] = 1: no memory request; buffer <= {pc, NOP_INST, fault=1} -> OUT next cycle.
REQ-035 Minimum latency: request accepted in cycle N, response in N+1 -> out_valid in N+2.
REQ-036 out_pc, out_inst, out_fault SHALL be held stable while out_valid=1 and out_ready=0.

Reset
REQ-037 rst at any edge: state <= REQ, pc <= RESET_PC, kill <= 0, fetch_count <= 0, buffer cleared.
REQ-038 During the rst cycle: imem_req_valid=0, imem_rsp_ready=0, out_valid=0, out_fault=0.
REQ-039 Reset mid-WAIT: the in-flight response SHALL be ignored (rsp_ready=0 in REQ).

Verification
REQ-040 Release rst, ready=1, rsp 1 cycle later data 0x00100093 -> req addr 0x80000000; out_valid with out_pc 0x80000000, out_inst 0x00100093; next req addr 0x80000004; fetch_count 1.
REQ-041 out_ready=0 for 5 cycles while in OUT -> outputs stable, no new request; ready=1 -> one handshake, count +1.
REQ-042 Redirect to 0x80000100 while in WAIT, response 0xdeadbeef arrives 3 cycles later -> response dropped, no out_valid; next request addr 0x80000100.
REQ-043 Response with imem_rsp_err=1 -> out_inst 0x00000013, out_fault 1.
REQ-044 Redirect to 0x80000102 -> no memory request; out_valid with out_pc 0x80000102, out_fault 1, out_inst 0x00000013.
REQ-045 Redirect during OUT, same cycle as out_ready=1 -> no handshake, count unchanged, next request at redirect target.

Source files
------------

// File: rtl/ifu_if.sv
// Instruction-fetch bus bundle.
// Groups the redirect input, the instruction-memory request/response
// channels, the IF/ID output channel and the delivered-instruction counter.
//   master : IFU side (drives imem_req_*, imem_rsp_ready, out_*, fetch_count)
//   slave  : environment side (memory, execute stage, IF/ID register)
interface ifu_if;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [63:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic        imem_rsp_ready;
  logic [31:0] imem_rsp_data;
  logic        imem_rsp_err;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_pc;
  logic [31:0] out_inst;
  logic        out_fault;
  logic [63:0] fetch_count;

  modport master (
    input  redirect_valid, redirect_pc,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data, imem_rsp_err,
    input  out_ready,
    output imem_req_valid, imem_req_addr, imem_rsp_ready,
    output out_valid, out_pc, out_inst, out_fault, fetch_count
  );

  modport slave (
    output redirect_valid, redirect_pc,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data, imem_rsp_err,
    output out_ready,
    input  imem_req_valid, imem_req_addr, imem_rsp_ready,
    input  out_valid, out_pc, out_inst, out_fault, fetch_count
  );
endinterface

// File: rtl/ifu.sv
// Instruction fetch unit.
// Issues one instruction-memory request at a time, buffers a single fetched
// instruction for the IF/ID register, and follows execute-stage redirects.
// Misaligned pcs (pc[1]=1) and memory access errors are delivered as faulting
// NOP instructions.
// Ports:
//   clk  - clock, all state updates on rising edge
//   rst  - synchronous active-high reset
//   bus  - ifu_if.master: redirect, imem request/response, IF/ID output,
//          fetch_count
module ifu #(
  parameter logic [63:0] RESET_PC = 64'h8000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic   clk,
  input  logic   rst,
  ifu_if.master  bus
);

  typedef enum logic [1:0] {
    S_REQ,
    S_WAIT,
    S_OUT
  } state_t;

  state_t      state, stateNext;
  logic [63:0] pc, pcNext;
  logic [63:0] reqPc;
  logic        kill, killNext;
  logic [63:0] fetchCount, countNext;
  logic [63:0] bufPc;
  logic [31:0] bufInst;
  logic        bufErr;

  logic        reqValid, rspReady, outValid;
  logic        reqPcLoad, bufLoadRsp, bufLoadFault;
  logic [63:0] redirectTarget;

  assign redirectTarget = {bus.redirect_pc[63:1], 1'b0};

  always_ff @(posedge clk) begin
    if (rst) state <= S_REQ;
    else     state <= stateNext;
  end

  always_comb begin
    stateNext    = state;
    pcNext       = pc;
    killNext     = kill;
    countNext    = fetchCount;
    reqValid     = 1'b0;
    rspReady     = 1'b0;
    outValid     = 1'b0;
    reqPcLoad    = 1'b0;
    bufLoadRsp   = 1'b0;
    bufLoadFault = 1'b0;
    if (!rst) begin
      unique case (state)
        S_REQ: begin
          if (bus.redirect_valid) begin
            pcNext = redirectTarget;
          end else if (pc[1]) begin
            // Misaligned fetch never reaches memory; a faulting NOP is queued.
            bufLoadFault = 1'b1;
            stateNext    = S_OUT;
          end else begin
            reqValid = 1'b1;
            if (bus.imem_req_ready) begin
              reqPcLoad = 1'b1;
              stateNext = S_WAIT;
            end
          end
        end
        S_WAIT: begin
          rspReady = 1'b1;
          if (bus.redirect_valid) begin
            pcNext = redirectTarget;
            if (bus.imem_rsp_valid) begin
              // Response arriving with the redirect is the stale one: drop it here.
              killNext  = 1'b0;
              stateNext = S_REQ;
            end else begin
              killNext = 1'b1;
            end
          end else if (bus.imem_rsp_valid) begin
            killNext = 1'b0;
            if (kill) begin
              stateNext = S_REQ;
            end else begin
              bufLoadRsp = 1'b1;
              stateNext  = S_OUT;
            end
          end
        end
        S_OUT: begin
          if (bus.redirect_valid) begin
            pcNext    = redirectTarget;
            stateNext = S_REQ;
          end else begin
            outValid = 1'b1;
            if (bus.out_ready) begin
              pcNext    = bufPc + 64'd4;
              countNext = fetchCount + 64'd1;
              stateNext = S_REQ;
            end
          end
        end
        default: stateNext = S_REQ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc         <= RESET_PC;
      kill       <= 1'b0;
      fetchCount <= '0;
      reqPc      <= '0;
      bufPc      <= '0;
      bufInst    <= '0;
      bufErr     <= 1'b0;
    end else begin
      pc         <= pcNext;
      kill       <= killNext;
      fetchCount <= countNext;
      if (reqPcLoad) reqPc <= pc;
      if (bufLoadRsp) begin
        bufPc   <= reqPc;
        bufInst <= bus.imem_rsp_data;
        bufErr  <= bus.imem_rsp_err;
      end else if (bufLoadFault) begin
        bufPc   <= pc;
        bufInst <= NOP_INST;
        bufErr  <= 1'b1;
      end
    end
  end

  assign bus.imem_req_valid = reqValid;
  assign bus.imem_req_addr  = pc;
  assign bus.imem_rsp_ready = rspReady;
  assign bus.out_valid      = outValid;
  assign bus.out_pc         = bufPc;
  assign bus.out_inst       = bufErr ? NOP_INST : bufInst;
  assign bus.out_fault      = bufErr && (state == S_OUT) && !rst;
  assign bus.fetch_count    = fetchCount;

endmodule

// File: tb/tb_ifu.sv
module tb_ifu;
  logic clk = 1'b0;
  logic rst;
  int unsigned errors = 0;
  int unsigned checks = 0;

  always #5 clk = ~clk;

  ifu_if bus();

  ifu #(
    .RESET_PC(64'h8000_0000),
    .NOP_INST(32'h0000_0013)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.master)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;
    bus.imem_req_ready = 1'b1;
    bus.imem_rsp_valid = 1'b0;
    bus.imem_rsp_data  = '0;
    bus.imem_rsp_err   = 1'b0;
    bus.out_ready      = 1'b0;

    // reset cycle
    tick();
    chk("rst_req_valid", 64'(bus.imem_req_valid), 64'd0);
    chk("rst_rsp_ready", 64'(bus.imem_rsp_ready), 64'd0);
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_out_fault", 64'(bus.out_fault), 64'd0);
    chk("rst_count", bus.fetch_count, 64'd0);

    // first fetch
    rst = 1'b0; #1;
    chk("f1_req_valid", 64'(bus.imem_req_valid), 64'd1);
    chk("f1_req_addr", bus.imem_req_addr, 64'h8000_0000);
    tick();
    bus.imem_rsp_valid = 1'b1; bus.imem_rsp_data = 32'h0010_0093; #1;
    chk("f1_rsp_ready", 64'(bus.imem_rsp_ready), 64'd1);
    chk("f1_wait_noreq", 64'(bus.imem_req_valid), 64'd0);
    tick();
    bus.imem_rsp_valid = 1'b0; bus.out_ready = 1'b1; #1;
    chk("f1_out_valid", 64'(bus.out_valid), 64'd1);
    chk("f1_out_pc", bus.out_pc, 64'h8000_0000);
    chk("f1_out_inst", 64'(bus.out_inst), 64'h0010_0093);
    chk("f1_out_fault", 64'(bus.out_fault), 64'd0);
    chk("f1_out_rsp_ready", 64'(bus.imem_rsp_ready), 64'd0);
    tick();
    bus.out_ready = 1'b0; #1;
    chk("f1_count", bus.fetch_count, 64'd1);
    chk("f2_req_valid", 64'(bus.imem_req_valid), 64'd1);
    chk("f2_req_addr", bus.imem_req_addr, 64'h8000_0004);

    // output stall for 5 cycles
    tick();
    bus.imem_rsp_valid = 1'b1; bus.imem_rsp_data = 32'h0020_0113;
    tick();
    bus.imem_rsp_valid = 1'b0; #1;
    for (int i = 0; i < 5; i++) begin
      chk("stall_out_valid", 64'(bus.out_valid), 64'd1);
      chk("stall_out_pc", bus.out_pc, 64'h8000_0004);
      chk("stall_out_inst", 64'(bus.out_inst), 64'h0020_0113);
      chk("stall_no_req", 64'(bus.imem_req_valid), 64'd0);
      tick();
    end
    bus.out_ready = 1'b1; #1;
    chk("stall_release_valid", 64'(bus.out_valid), 64'd1);
    tick();
    bus.out_ready = 1'b0; #1;
    chk("stall_count", bus.fetch_count, 64'd2);
    chk("f3_req_addr", bus.imem_req_addr, 64'h8000_0008);
    chk("f3_req_valid", 64'(bus.imem_req_valid), 64'd1);

    // redirect while waiting, late response dropped
    tick();
    bus.redirect_valid = 1'b1; bus.redirect_pc = 64'h8000_0100; #1;
    chk("kill_rsp_ready", 64'(bus.imem_rsp_ready), 64'd1);
    tick();
    bus.redirect_valid = 1'b0; #1;
    chk("kill_no_out", 64'(bus.out_valid), 64'd0);
    tick();
    tick();
    bus.imem_rsp_valid = 1'b1; bus.imem_rsp_data = 32'hdead_beef; #1;
    chk("kill_rsp_ready2", 64'(bus.imem_rsp_ready), 64'd1);
    tick();
    bus.imem_rsp_valid = 1'b0; #1;
    chk("kill_dropped", 64'(bus.out_valid), 64'd0);
    chk("kill_req_valid", 64'(bus.imem_req_valid), 64'd1);
    chk("kill_req_addr", bus.imem_req_addr, 64'h8000_0100);
    chk("kill_count", bus.fetch_count, 64'd2);

    // access fault response
    tick();
    bus.imem_rsp_valid = 1'b1; bus.imem_rsp_data = 32'h1234_5678; bus.imem_rsp_err = 1'b1;
    tick();
    bus.imem_rsp_valid = 1'b0; bus.imem_rsp_err = 1'b0; #1;
    chk("err_out_valid", 64'(bus.out_valid), 64'd1);
    chk("err_out_pc", bus.out_pc, 64'h8000_0100);
    chk("err_out_inst", 64'(bus.out_inst), 64'h0000_0013);
    chk("err_out_fault", 64'(bus.out_fault), 64'd1);
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    chk("err_count", bus.fetch_count, 64'd3);

    // redirect to misaligned target (bit 0 is cleared by the IFU)
    bus.redirect_valid = 1'b1; bus.redirect_pc = 64'h8000_0103; #1;
    chk("mis_redir_no_req", 64'(bus.imem_req_valid), 64'd0);
    tick();
    bus.redirect_valid = 1'b0; #1;
    chk("mis_no_req", 64'(bus.imem_req_valid), 64'd0);
    chk("mis_pc", bus.imem_req_addr, 64'h8000_0102);
    tick();
    chk("mis_out_valid", 64'(bus.out_valid), 64'd1);
    chk("mis_out_pc", bus.out_pc, 64'h8000_0102);
    chk("mis_out_fault", 64'(bus.out_fault), 64'd1);
    chk("mis_out_inst", 64'(bus.out_inst), 64'h0000_0013);

    // redirect in OUT together with out_ready
    bus.out_ready = 1'b1; bus.redirect_valid = 1'b1; bus.redirect_pc = 64'h8000_0200; #1;
    chk("outredir_valid", 64'(bus.out_valid), 64'd0);
    tick();
    bus.redirect_valid = 1'b0; bus.out_ready = 1'b0; #1;
    chk("outredir_count", bus.fetch_count, 64'd3);
    chk("outredir_req_valid", 64'(bus.imem_req_valid), 64'd1);
    chk("outredir_req_addr", bus.imem_req_addr, 64'h8000_0200);

    // repeated redirects while killing: exactly one response dropped
    tick();
    bus.redirect_valid = 1'b1; bus.redirect_pc = 64'h8000_0300;
    tick();
    bus.redirect_pc = 64'h8000_0400;
    tick();
    bus.redirect_valid = 1'b0; bus.imem_rsp_valid = 1'b1; bus.imem_rsp_data = 32'haaaa_aaaa;
    tick();
    bus.imem_rsp_valid = 1'b0; #1;
    chk("rep_dropped", 64'(bus.out_valid), 64'd0);
    chk("rep_req_addr", bus.imem_req_addr, 64'h8000_0400);
    chk("rep_req_valid", 64'(bus.imem_req_valid), 64'd1);
    tick();
    bus.imem_rsp_valid = 1'b1; bus.imem_rsp_data = 32'h0030_0193;
    tick();
    bus.imem_rsp_valid = 1'b0; #1;
    chk("rep_out_valid", 64'(bus.out_valid), 64'd1);
    chk("rep_out_pc", bus.out_pc, 64'h8000_0400);
    chk("rep_out_inst", 64'(bus.out_inst), 64'h0030_0193);

    // redirect in WAIT with same-cycle response
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    tick();
    bus.redirect_valid = 1'b1; bus.redirect_pc = 64'h8000_0500;
    bus.imem_rsp_valid = 1'b1; bus.imem_rsp_data = 32'hbbbb_bbbb;
    tick();
    bus.redirect_valid = 1'b0; bus.imem_rsp_valid = 1'b0; #1;
    chk("same_no_out", 64'(bus.out_valid), 64'd0);
    chk("same_req_addr", bus.imem_req_addr, 64'h8000_0500);
    chk("same_count", bus.fetch_count, 64'd4);
    tick();
    bus.imem_rsp_valid = 1'b1; bus.imem_rsp_data = 32'h0040_0213;
    tick();
    bus.imem_rsp_valid = 1'b0; #1;
    chk("same_out_valid", 64'(bus.out_valid), 64'd1);
    chk("same_out_pc", bus.out_pc, 64'h8000_0500);
    chk("same_out_inst", 64'(bus.out_inst), 64'h0040_0213);

    // reset while waiting for a response
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    chk("pre_rst_count", bus.fetch_count, 64'd5);
    tick();
    rst = 1'b1; bus.imem_rsp_valid = 1'b1; bus.imem_rsp_data = 32'hcccc_cccc; #1;
    chk("midrst_rsp_ready", 64'(bus.imem_rsp_ready), 64'd0);
    chk("midrst_req_valid", 64'(bus.imem_req_valid), 64'd0);
    chk("midrst_out_valid", 64'(bus.out_valid), 64'd0);
    tick();
    rst = 1'b0; #1;
    chk("postrst_count", bus.fetch_count, 64'd0);
    chk("postrst_req_addr", bus.imem_req_addr, 64'h8000_0000);
    chk("postrst_req_valid", 64'(bus.imem_req_valid), 64'd1);
    chk("postrst_rsp_ready", 64'(bus.imem_rsp_ready), 64'd0);
    chk("postrst_out_valid", 64'(bus.out_valid), 64'd0);
    bus.imem_rsp_valid = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
